// File: rtl/ram8_bank.sv
// Eight-entry register bank feeding Mux8Way16 a..h, plus the sel generator that either
// follows a host read address or sweeps indices 0..7 for a full dump.
module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr,
    input  logic             scan_start,
    output logic [WIDTH-1:0] word_a,
    output logic [WIDTH-1:0] word_b,
    output logic [WIDTH-1:0] word_c,
    output logic [WIDTH-1:0] word_d,
    output logic [WIDTH-1:0] word_e,
    output logic [WIDTH-1:0] word_f,
    output logic [WIDTH-1:0] word_g,
    output logic [WIDTH-1:0] word_h,
    output logic [2:0]       sel,
    output logic             scan_valid,
    output logic             scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sel;
    logic             r_scan_valid;
    logic             r_scan_done;
    logic [WIDTH-1:0] r_mem [8];
    logic             w_wr_fire;

    // Writes are only possible in IDLE, which keeps the entries frozen for the whole scan.
    assign wr_ready  = (r_state == ST_IDLE);
    assign w_wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 3'd0;
            r_scan_valid <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_scan_done <= 1'b0;
                    if (scan_start) begin
                        r_state      <= ST_SCAN;
                        r_sel        <= 3'd0;
                        r_scan_valid <= 1'b1;
                    end else begin
                        r_sel        <= rd_addr;
                        r_scan_valid <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Index 7 leaves the scan instead of wrapping, so sel stays on the last word.
                    if (r_sel == 3'd7) begin
                        r_state      <= ST_DONE;
                        r_scan_valid <= 1'b0;
                        r_scan_done  <= 1'b1;
                    end else begin
                        r_sel        <= r_sel + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_scan_valid <= 1'b0;
                    r_scan_done  <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_scan_valid <= 1'b0;
                    r_scan_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign scan_valid = r_scan_valid;
    assign scan_done  = r_scan_done;

    assign word_a = r_mem[0];
    assign word_b = r_mem[1];
    assign word_c = r_mem[2];
    assign word_d = r_mem[3];
    assign word_e = r_mem[4];
    assign word_f = r_mem[5];
    assign word_g = r_mem[6];
    assign word_h = r_mem[7];

endmodule

// File: tb/tb_ram8_bank.sv
// Directed bench for ram8_bank: reset, writes, host read, scans and their boundary cases.
module tb_ram8_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic        scan_start;
    logic [15:0] word_a, word_b, word_c, word_d, word_e, word_f, word_g, word_h;
    logic [2:0]  sel;
    logic        scan_valid;
    logic        scan_done;

    logic [15:0] words   [8];
    logic [15:0] exp_mem [8];
    int          n_checks;
    int          n_fail;

    ram8_bank #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .scan_start (scan_start),
        .word_a     (word_a),
        .word_b     (word_b),
        .word_c     (word_c),
        .word_d     (word_d),
        .word_e     (word_e),
        .word_f     (word_f),
        .word_g     (word_g),
        .word_h     (word_h),
        .sel        (sel),
        .scan_valid (scan_valid),
        .scan_done  (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        words[0] = word_a;
        words[1] = word_b;
        words[2] = word_c;
        words[3] = word_d;
        words[4] = word_e;
        words[5] = word_f;
        words[6] = word_g;
        words[7] = word_h;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = 16'h0000;
            n_checks++;
            if (words[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_word[%0d] got %h expected 0000", i, words[i]);
            end
        end
        n_checks++;
        if (sel !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_sel got %0d expected 0", sel);
        end
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr_ready got %b expected 1", wr_ready);
        end
        n_checks++;
        if (scan_valid !== 1'b0 || scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scan_flags got valid=%b done=%b expected 0/0", scan_valid, scan_done);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 3'(i);
            wr_data  = 16'h1110 + 16'(i);
            n_checks++;
            if (wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL write_ready[%0d] got %b expected 1", i, wr_ready);
            end
            tick();
            exp_mem[i] = 16'h1110 + 16'(i);
            n_checks++;
            if (words[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL write_word[%0d] got %h expected %h", i, words[i], exp_mem[i]);
            end
        end
        wr_valid = 1'b0;
        rd_addr  = 3'd5;
        tick();
        n_checks++;
        if (sel !== 3'd5 || word_f !== 16'h1115) begin
            n_fail++;
            $display("FAIL host_read got sel=%0d word_f=%h expected sel=5 word_f=1115", sel, word_f);
        end
        rd_addr = 3'd0;
        tick();
    endtask

    task automatic test_scan();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (scan_valid !== 1'b1 || sel !== 3'(k) || words[k] !== exp_mem[k]) begin
                n_fail++;
                $display("FAIL scan_step[%0d] got valid=%b sel=%0d word=%h expected 1/%0d/%h",
                         k, scan_valid, sel, words[k], k, exp_mem[k]);
            end
            n_checks++;
            if (scan_done !== 1'b0 || wr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_ctl[%0d] got done=%b ready=%b expected 0/0", k, scan_done, wr_ready);
            end
            // A start request mid-scan must be ignored.
            scan_start = (k == 3);
            tick();
            scan_start = 1'b0;
        end
        n_checks++;
        if (scan_done !== 1'b1 || scan_valid !== 1'b0 || sel !== 3'd7) begin
            n_fail++;
            $display("FAIL scan_done_cycle got done=%b valid=%b sel=%0d expected 1/0/7", scan_done, scan_valid, sel);
        end
        tick();
        n_checks++;
        if (scan_done !== 1'b0 || scan_valid !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_end got done=%b valid=%b ready=%b expected 0/0/1", scan_done, scan_valid, wr_ready);
        end
    endtask

    task automatic test_mid_scan_write();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        wr_valid   = 1'b1;
        wr_addr    = 3'd2;
        wr_data    = 16'hBEEF;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (wr_ready !== 1'b0 || word_c !== exp_mem[2]) begin
                n_fail++;
                $display("FAIL midscan_block[%0d] got ready=%b word_c=%h expected 0/%h", k, wr_ready, word_c, exp_mem[2]);
            end
            tick();
        end
        n_checks++;
        if (scan_done !== 1'b1 || wr_ready !== 1'b0 || word_c !== exp_mem[2]) begin
            n_fail++;
            $display("FAIL midscan_done got done=%b ready=%b word_c=%h expected 1/0/%h", scan_done, wr_ready, word_c, exp_mem[2]);
        end
        tick();
        n_checks++;
        if (wr_ready !== 1'b1 || word_c !== exp_mem[2]) begin
            n_fail++;
            $display("FAIL midscan_idle got ready=%b word_c=%h expected 1/%h", wr_ready, word_c, exp_mem[2]);
        end
        tick();
        wr_valid   = 1'b0;
        exp_mem[2] = 16'hBEEF;
        n_checks++;
        if (word_c !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL midscan_accept got word_c=%h expected beef", word_c);
        end
    endtask

    task automatic test_same_cycle();
        wr_valid   = 1'b1;
        wr_addr    = 3'd0;
        wr_data    = 16'hA5A5;
        scan_start = 1'b1;
        tick();
        wr_valid   = 1'b0;
        scan_start = 1'b0;
        exp_mem[0] = 16'hA5A5;
        n_checks++;
        if (scan_valid !== 1'b1 || sel !== 3'd0 || word_a !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL same_cycle got valid=%b sel=%0d word_a=%h expected 1/0/a5a5", scan_valid, sel, word_a);
        end
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (scan_done !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_done got %b expected 1", scan_done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1;
        wr_addr  = 3'd7;
        wr_data  = 16'h0001;
        tick();
        wr_data  = 16'h0002;
        tick();
        wr_valid   = 1'b0;
        exp_mem[7] = 16'h0002;
        n_checks++;
        if (word_h !== 16'h0002 || word_g !== exp_mem[6]) begin
            n_fail++;
            $display("FAIL back_to_back got word_h=%h word_g=%h expected 0002/%h", word_h, word_g, exp_mem[6]);
        end
    endtask

    task automatic test_reset_mid_scan();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (sel !== 3'd4 || scan_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup got sel=%0d valid=%b expected 4/1", sel, scan_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (scan_valid !== 1'b0 || scan_done !== 1'b0 || wr_ready !== 1'b1 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_state got valid=%b done=%b ready=%b sel=%0d expected 0/0/1/0",
                     scan_valid, scan_done, wr_ready, sel);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (words[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL abort_word[%0d] got %h expected 0000", i, words[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (scan_done !== 1'b0 || scan_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d] got done=%b valid=%b expected 0/0", k, scan_done, scan_valid);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 16'h0000;
        rd_addr    = 3'd0;
        scan_start = 1'b0;
        test_reset();
        test_write_read();
        test_scan();
        test_mid_scan_write();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
